// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC sequencer.
//   stage_e        : stage encoding, also driven out on pc_sequencer.stage
//   nsel_e         : next-address source selected when entering UPDATE
//   DEFAULT_*      : default reset address and sequential increment
//   pick_nsel()    : priority encoder ret > call > jump > taken branch > seq
package pc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        UPDATE  = 3'd5
    } stage_e;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4
    } nsel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INCR  = 32'd4;

    function automatic nsel_e pick_nsel(input logic ret, input logic call,
                                        input logic jump, input logic branch,
                                        input logic taken);
        nsel_e sel;
        sel = SEQ;
        if (ret)                  sel = RET;
        else if (call)            sel = CALL;
        else if (jump)            sel = JMP;
        else if (branch && taken) sel = BR;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   push       : write push_data as the new most-recent entry
//   pop        : discard the most-recent entry (ignored when empty)
//   push_data  : value to push
//   top        : most-recent entry (valid when !empty)
//   empty/full : occupancy flags
// A push when full overwrites the oldest entry and count stays at DEPTH.
// If push and pop arrive together, push wins (the sequencer never does this).
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] ONE     = 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;    // next slot to write; ptr-1 is the top
    logic [PW:0]   count;

    assign top   = mem[ptr - ONE];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + ONE;
            if (!full) begin
                count <= count + CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - ONE;
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer driving the PC register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   pc_in          : current PC from the PC register (latched in DECODE)
//   is_branch/is_jump/is_call/is_ret/has_mem/has_wb, imm_offset,
//   jump_target    : decode fields, latched on the DECODE -> EXECUTE edge
//   branch_taken   : ALU compare, latched on the edge leaving EXECUTE
//   mem_ready      : data memory done; MEM is left on an edge where it is 1
//   next_pc        : registered address for the PC register
//   disablepc      : registered hold, 0 only while in UPDATE
//   stage          : current stage (stage_e encoding)
//   ras_underflow  : sticky, set by a return with an empty RAS
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INCR   = DEFAULT_PC_INCR,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_call,
    input  logic        is_ret,
    input  logic        has_mem,
    input  logic        has_wb,
    input  logic [31:0] imm_offset,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic [31:0] next_pc,
    output logic        disablepc,
    output logic [2:0]  stage,
    output logic        ras_underflow
);

    stage_e state_q, state_d;

    // Latched decode fields
    logic [31:0] pc_q, imm_q, tgt_q;
    logic        br_q, jmp_q, call_q, ret_q, mem_q, wb_q, taken_q;

    logic        entering_update;
    logic        taken_eff;
    nsel_e       nsel;
    logic [31:0] pc_seq;
    logic [31:0] npc_d;
    logic        ras_push, ras_pop, set_uf;
    logic [31:0] ras_top;
    logic        ras_empty, ras_full;

    pc_ras #(.DEPTH(RAS_DEPTH), .W(32)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-stage logic. mem_ready is a level "done" indication: MEM is left
    // on the first rising edge where it is sampled high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = mem_q ? MEM : (wb_q ? WB : UPDATE);
            MEM:     if (mem_ready) state_d = wb_q ? WB : UPDATE;
            WB:      state_d = UPDATE;
            UPDATE:  state_d = FETCH;
            default: state_d = UPDATE;
        endcase
    end

    assign entering_update = (state_d == UPDATE) && (state_q != UPDATE);

    // When EXECUTE goes straight to UPDATE, the compare result is being
    // latched on the same edge, so use the live input in that case.
    assign taken_eff = (state_q == EXECUTE) ? branch_taken : taken_q;
    assign nsel      = pick_nsel(ret_q, call_q, jmp_q, br_q, taken_eff);
    assign pc_seq    = pc_q + PC_INCR;

    always_comb begin
        npc_d    = pc_seq;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        set_uf   = 1'b0;
        case (nsel)
            RET: begin
                if (!ras_empty) begin
                    npc_d   = ras_top;
                    ras_pop = entering_update;
                end else begin
                    set_uf = 1'b1;
                end
            end
            CALL: begin
                npc_d    = tgt_q;
                ras_push = entering_update;
            end
            JMP:     npc_d = tgt_q;
            BR:      npc_d = pc_q + imm_q;
            default: npc_d = pc_seq;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= UPDATE;
            next_pc       <= RESET_PC;
            disablepc     <= 1'b0;
            ras_underflow <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            tgt_q         <= '0;
            br_q          <= 1'b0;
            jmp_q         <= 1'b0;
            call_q        <= 1'b0;
            ret_q         <= 1'b0;
            mem_q         <= 1'b0;
            wb_q          <= 1'b0;
            taken_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            disablepc <= (state_d != UPDATE);
            if (state_q == DECODE) begin
                pc_q   <= pc_in;
                imm_q  <= imm_offset;
                tgt_q  <= jump_target;
                br_q   <= is_branch;
                jmp_q  <= is_jump;
                call_q <= is_call;
                ret_q  <= is_ret;
                mem_q  <= has_mem;
                wb_q   <= has_wb;
            end
            if (state_q == EXECUTE) begin
                taken_q <= branch_taken;
            end
            if (entering_update) begin
                next_pc <= npc_d;
                if (set_uf) begin
                    ras_underflow <= 1'b1;
                end
            end
        end
    end

    assign stage = state_q;

endmodule
